video_timing_gen: RTL and testbench



---
 rtl/video_timing_gen.sv | 188 ++++++++++++++++++
 tb/tb_video_timing_gen.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: horizontal/vertical counters,
// registered sync/data-enable/coordinate outputs, and a pending timing
// configuration that takes effect only at a frame boundary or while idle.
module video_timing_gen #(
    parameter int unsigned CW     = 12,
    parameter int unsigned FCW    = 16,
    parameter int unsigned H_ACT  = 1024,
    parameter int unsigned H_FP   = 24,
    parameter int unsigned H_SYNC = 136,
    parameter int unsigned H_BP   = 160,
    parameter int unsigned V_ACT  = 768,
    parameter int unsigned V_FP   = 3,
    parameter int unsigned V_SYNC = 6,
    parameter int unsigned V_BP   = 29,
    parameter logic        HS_POL = 1'b0,
    parameter logic        VS_POL = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            cfg_load,
    input  logic [4*CW-1:0] cfg_h,
    input  logic [4*CW-1:0] cfg_v,
    input  logic [1:0]      cfg_pol,
    output logic            cfg_err,
    output logic            hs,
    output logic            vs,
    output logic            de,
    output logic [CW-1:0]   x,
    output logic [CW-1:0]   y,
    output logic            line_start,
    output logic            frame_start,
    output logic [FCW-1:0]  frame_cnt
);
    // Timing sums are done two bits wider so four full-scale fields cannot wrap.
    localparam int unsigned     XW      = CW + 2;
    localparam logic [XW-1:0]   MAX_TOT = XW'((1 << CW) - 1);
    localparam logic [4*CW-1:0] DEF_H   = {CW'(H_ACT), CW'(H_FP), CW'(H_SYNC), CW'(H_BP)};
    localparam logic [4*CW-1:0] DEF_V   = {CW'(V_ACT), CW'(V_FP), CW'(V_SYNC), CW'(V_BP)};
    localparam logic [1:0]      DEF_POL = {HS_POL, VS_POL};

    // Field idx 0..3 = act, fp, sync, bp (act in the MSBs), zero-extended.
    function automatic logic [XW-1:0] fld(input logic [4*CW-1:0] c, input int unsigned idx);
        return {2'b00, c[(3-idx)*CW +: CW]};
    endfunction

    function automatic logic axis_ok(input logic [4*CW-1:0] c);
        logic [XW-1:0] sum;
        logic          ok;
        sum = '0;
        ok  = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            sum = sum + fld(c, i);
            if (fld(c, i) == '0) ok = 1'b0;
        end
        return ok && (sum <= MAX_TOT);
    endfunction

    logic [CW-1:0]   h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [4*CW-1:0] act_h_q, act_h_d, act_v_q, act_v_d;
    logic [4*CW-1:0] pend_h_q, pend_h_d, pend_v_q, pend_v_d;
    logic [1:0]      act_pol_q, act_pol_d, pend_pol_q, pend_pol_d;
    logic            pend_vld_q, pend_vld_d;
    logic            cfg_err_q, cfg_err_d, hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic            ls_q, ls_d, fs_q, fs_d;
    logic [CW-1:0]   x_q, x_d, y_q, y_d;
    logic [FCW-1:0]  fcnt_q, fcnt_d;

    logic [XW-1:0]   h_ext, v_ext, h_tot, v_tot, hs_lo, hs_hi, vs_lo, vs_hi;
    logic            h_last, v_last, apply, load_ok;

    // Decode the live counter position against the active timing.
    always_comb begin
        h_ext  = {2'b00, h_cnt_q};
        v_ext  = {2'b00, v_cnt_q};
        hs_lo  = fld(act_h_q, 0) + fld(act_h_q, 1);
        hs_hi  = hs_lo + fld(act_h_q, 2);
        h_tot  = hs_hi + fld(act_h_q, 3);
        vs_lo  = fld(act_v_q, 0) + fld(act_v_q, 1);
        vs_hi  = vs_lo + fld(act_v_q, 2);
        v_tot  = vs_hi + fld(act_v_q, 3);
        h_last = (h_ext == h_tot - XW'(1));
        v_last = (v_ext == v_tot - XW'(1));
    end

    // Next counters, config hand-over and the registered output values.
    always_comb begin
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        act_h_d    = act_h_q;
        act_v_d    = act_v_q;
        act_pol_d  = act_pol_q;
        pend_h_d   = pend_h_q;
        pend_v_d   = pend_v_q;
        pend_pol_d = pend_pol_q;
        pend_vld_d = pend_vld_q;

        if (!en) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_last) begin
            h_cnt_d = '0;
            v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
        end else begin
            h_cnt_d = h_cnt_q + 1'b1;
        end

        // Hand-over uses the old pending value; a coincident load then
        // refills pending so it waits for the following boundary.
        apply = !en || (h_last && v_last);
        if (apply && pend_vld_q) begin
            act_h_d    = pend_h_q;
            act_v_d    = pend_v_q;
            act_pol_d  = pend_pol_q;
            pend_vld_d = 1'b0;
        end
        load_ok = cfg_load && axis_ok(cfg_h) && axis_ok(cfg_v);
        if (load_ok) begin
            pend_h_d   = cfg_h;
            pend_v_d   = cfg_v;
            pend_pol_d = cfg_pol;
            pend_vld_d = 1'b1;
        end
        cfg_err_d = cfg_load && !load_ok;

        de_d   = en && (h_ext < fld(act_h_q, 0)) && (v_ext < fld(act_v_q, 0));
        x_d    = de_d ? h_cnt_q : '0;
        y_d    = de_d ? v_cnt_q : '0;
        hs_d   = (en && h_ext >= hs_lo && h_ext < hs_hi) ? act_pol_q[1] : ~act_pol_q[1];
        vs_d   = (en && v_ext >= vs_lo && v_ext < vs_hi) ? act_pol_q[0] : ~act_pol_q[0];
        ls_d   = de_d && (h_cnt_q == '0);
        fs_d   = en && (h_cnt_q == '0) && (v_cnt_q == '0);
        fcnt_d = fcnt_q + {{(FCW-1){1'b0}}, fs_d};
    end

    // State and output registers with asynchronous return to defaults.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            act_h_q    <= DEF_H;
            act_v_q    <= DEF_V;
            act_pol_q  <= DEF_POL;
            pend_h_q   <= DEF_H;
            pend_v_q   <= DEF_V;
            pend_pol_q <= DEF_POL;
            pend_vld_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            hs_q       <= ~HS_POL;
            vs_q       <= ~VS_POL;
            de_q       <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            ls_q       <= 1'b0;
            fs_q       <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            act_h_q    <= act_h_d;
            act_v_q    <= act_v_d;
            act_pol_q  <= act_pol_d;
            pend_h_q   <= pend_h_d;
            pend_v_q   <= pend_v_d;
            pend_pol_q <= pend_pol_d;
            pend_vld_q <= pend_vld_d;
            cfg_err_q  <= cfg_err_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            de_q       <= de_d;
            x_q        <= x_d;
            y_q        <= y_d;
            ls_q       <= ls_d;
            fs_q       <= fs_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign cfg_err     = cfg_err_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_cnt   = fcnt_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: directed timing scenarios plus
// randomized enable/config traffic against a frame-position reference model.
module tb_video_timing_gen;
    localparam int CW  = 12;
    localparam int FCW = 16;
    localparam int DW  = 6 + 2*CW + FCW;

    logic            clk = 1'b0;
    logic            rst_n, en, cfg_load;
    logic [4*CW-1:0] cfg_h, cfg_v;
    logic [1:0]      cfg_pol;
    logic            cfg_err, hs, vs, de, line_start, frame_start;
    logic [CW-1:0]   x, y;
    logic [FCW-1:0]  frame_cnt;
    logic [DW-1:0]   obs;

    video_timing_gen #(.CW(CW), .FCW(FCW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_load(cfg_load),
        .cfg_h(cfg_h), .cfg_v(cfg_v), .cfg_pol(cfg_pol), .cfg_err(cfg_err),
        .hs(hs), .vs(vs), .de(de), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;
    assign obs = {cfg_err, hs, vs, de, line_start, frame_start, x, y, frame_cnt};

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int fs_q[$];
    int ls_q[$];

    // Reference model: timing as field arrays {act,fp,sync,bp}, position as a
    // linear pixel index inside the frame.
    int   a_h[4], a_v[4], p_h[4], p_v[4];
    logic a_hp, a_vp, p_hp, p_vp, p_vld;
    int   m_pos, m_fc;
    logic e_err, e_hs, e_vs, e_de, e_ls, e_fs;
    int   e_x, e_y;

    function automatic logic [4*CW-1:0] mk(input int a, input int f, input int s, input int b);
        logic [CW-1:0] fa, ff, fsy, fb;
        fa = CW'(a); ff = CW'(f); fsy = CW'(s); fb = CW'(b);
        return {fa, ff, fsy, fb};
    endfunction

    function automatic int field(input logic [4*CW-1:0] c, input int i);
        logic [4*CW-1:0] t;
        t = c >> ((3 - i) * CW);
        return int'(t[CW-1:0]);
    endfunction

    function automatic bit legal_axis(input logic [4*CW-1:0] c);
        int s;
        bit ok;
        s = 0;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (field(c, i) == 0) ok = 1'b0;
            s += field(c, i);
        end
        return ok && (s <= (1 << CW) - 1);
    endfunction

    function automatic logic [DW-1:0] exp_vec();
        return {e_err, e_hs, e_vs, e_de, e_ls, e_fs, CW'(e_x), CW'(e_y), FCW'(m_fc)};
    endfunction

    task automatic model_reset();
        a_h = '{1024, 24, 136, 160};
        a_v = '{768, 3, 6, 29};
        p_h = a_h; p_v = a_v;
        a_hp = 1'b0; a_vp = 1'b0; p_hp = 1'b0; p_vp = 1'b0; p_vld = 1'b0;
        m_pos = 0; m_fc = 0;
        e_err = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_ls = 1'b0; e_fs = 1'b0;
        e_x = 0; e_y = 0;
    endtask

    task automatic model_step();
        int ht, vt, h, v;
        bit lg, apply;
        ht = a_h[0] + a_h[1] + a_h[2] + a_h[3];
        vt = a_v[0] + a_v[1] + a_v[2] + a_v[3];
        lg = legal_axis(cfg_h) && legal_axis(cfg_v);
        e_err = cfg_load && !lg;
        if (!en) begin
            e_de = 1'b0; e_x = 0; e_y = 0; e_ls = 1'b0; e_fs = 1'b0;
            e_hs = !a_hp; e_vs = !a_vp;
        end else begin
            h = m_pos % ht;
            v = m_pos / ht;
            e_de = (h < a_h[0]) && (v < a_v[0]);
            e_x = e_de ? h : 0;
            e_y = e_de ? v : 0;
            e_hs = (h >= a_h[0] + a_h[1] && h < a_h[0] + a_h[1] + a_h[2]) ? a_hp : !a_hp;
            e_vs = (v >= a_v[0] + a_v[1] && v < a_v[0] + a_v[1] + a_v[2]) ? a_vp : !a_vp;
            e_ls = e_de && (h == 0);
            e_fs = (m_pos == 0);
            if (e_fs) m_fc = (m_fc + 1) % (1 << FCW);
        end
        apply = !en || (m_pos == ht * vt - 1);
        m_pos = en ? (m_pos + 1) % (ht * vt) : 0;
        if (apply && p_vld) begin
            a_h = p_h; a_v = p_v; a_hp = p_hp; a_vp = p_vp; p_vld = 1'b0;
        end
        if (cfg_load && lg) begin
            for (int i = 0; i < 4; i++) begin
                p_h[i] = field(cfg_h, i);
                p_v[i] = field(cfg_v, i);
            end
            p_hp = cfg_pol[1]; p_vp = cfg_pol[0]; p_vld = 1'b1;
        end
    endtask

    task automatic tick(input logic e, input logic ld, input logic [4*CW-1:0] ch,
                        input logic [4*CW-1:0] cv, input logic [1:0] cp);
        en = e; cfg_load = ld; cfg_h = ch; cfg_v = cv; cfg_pol = cp;
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        cfg_load = 1'b0;
        if (frame_start) fs_q.push_back(cyc);
        if (line_start) ls_q.push_back(cyc);
    endtask

    task automatic run(input logic e);
        tick(e, 1'b0, cfg_h, cfg_v, cfg_pol);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; cfg_load = 1'b0; cfg_h = '0; cfg_v = '0; cfg_pol = 2'b00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (obs !== exp_vec()) $display("FAIL reset_state got=%h exp=%h", obs, exp_vec());
        else n_pass++;
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run(1'b0);
            n_total++;
            if (obs !== exp_vec()) $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_small_cfg();
        logic [2:0] shape;
        tick(1'b0, 1'b1, mk(8, 2, 2, 2), mk(4, 1, 1, 1), 2'b00);
        n_total++;
        if (obs !== exp_vec()) $display("FAIL small_load cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
        else n_pass++;
        run(1'b0);
        for (int k = 0; k < 196; k++) begin
            run(1'b1);
            n_total++;
            if (obs !== exp_vec()) $display("FAIL small_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            else n_pass++;
            shape = {(k % 14 < 8) && ((k / 14) % 7 < 4),
                     !((k % 14) >= 10 && (k % 14) < 12),
                     !((k / 14) % 7 == 5)};
            n_total++;
            if ({de, hs, vs} !== shape) $display("FAIL small_shape k=%0d got=%b exp=%b", k, {de, hs, vs}, shape);
            else n_pass++;
        end
        n_total++;
        if (frame_cnt !== 16'd2) $display("FAIL small_frame_cnt got=%0d exp=2", frame_cnt);
        else n_pass++;
    endtask

    task automatic test_midframe_cfg();
        int n;
        fs_q.delete();
        for (int k = 0; k < 40; k++) begin
            run(1'b1);
            n_total++;
            if (obs !== exp_vec()) $display("FAIL mid_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            else n_pass++;
        end
        tick(1'b1, 1'b1, mk(16, 1, 1, 1), mk(4, 1, 1, 1), 2'b00);
        n_total++;
        if (obs !== exp_vec()) $display("FAIL mid_load cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
        else n_pass++;
        n = 0;
        while (fs_q.size() < 3 && n < 400) begin
            run(1'b1);
            n++;
            n_total++;
            if (obs !== exp_vec()) $display("FAIL mid_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (fs_q.size() < 3) $display("FAIL mid_timeout got=%0d frame_starts exp=3", fs_q.size());
        else begin
            n_pass++;
            n_total++;
            if (fs_q[1] - fs_q[0] !== 98) $display("FAIL mid_old_frame got=%0d exp=98", fs_q[1] - fs_q[0]);
            else n_pass++;
            n_total++;
            if (fs_q[2] - fs_q[1] !== 133) $display("FAIL mid_new_frame got=%0d exp=133", fs_q[2] - fs_q[1]);
            else n_pass++;
        end
    endtask

    task automatic test_bad_cfg();
        int n;
        tick(1'b1, 1'b1, mk(8, 2, 0, 2), mk(4, 1, 1, 1), 2'b11);
        n_total++;
        if (cfg_err !== 1'b1) $display("FAIL err_sync0_pulse got=%b exp=1", cfg_err);
        else n_pass++;
        run(1'b1);
        n_total++;
        if (cfg_err !== 1'b0) $display("FAIL err_sync0_width got=%b exp=0", cfg_err);
        else n_pass++;
        tick(1'b1, 1'b1, mk(4000, 50, 50, 50), mk(4, 1, 1, 1), 2'b00);
        n_total++;
        if (cfg_err !== 1'b1) $display("FAIL err_ovf_pulse got=%b exp=1", cfg_err);
        else n_pass++;
        run(1'b1);
        n_total++;
        if (obs !== exp_vec()) $display("FAIL err_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
        else n_pass++;
        fs_q.delete();
        n = 0;
        while (fs_q.size() < 2 && n < 400) begin
            run(1'b1);
            n++;
            n_total++;
            if (obs !== exp_vec()) $display("FAIL err_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (fs_q.size() < 2 || fs_q[1] - fs_q[0] !== 133)
            $display("FAIL err_timing_kept got=%0d exp=133", fs_q.size() < 2 ? -1 : fs_q[1] - fs_q[0]);
        else n_pass++;
        // Legal load followed by an illegal one: the legal one must survive.
        tick(1'b1, 1'b1, mk(10, 1, 1, 1), mk(4, 1, 1, 1), 2'b00);
        tick(1'b1, 1'b1, mk(10, 1, 1, 0), mk(4, 1, 1, 1), 2'b00);
        n_total++;
        if (obs !== exp_vec()) $display("FAIL err_keep_pending cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
        else n_pass++;
        fs_q.delete();
        n = 0;
        while (fs_q.size() < 2 && n < 400) begin
            run(1'b1);
            n++;
            n_total++;
            if (obs !== exp_vec()) $display("FAIL err_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (fs_q.size() < 2 || fs_q[1] - fs_q[0] !== 91)
            $display("FAIL err_pending_kept got=%0d exp=91", fs_q.size() < 2 ? -1 : fs_q[1] - fs_q[0]);
        else n_pass++;
    endtask

    task automatic test_en_gap();
        int n;
        logic [FCW-1:0] fc0;
        n = 0;
        while (!(de && x == 12'd3 && y == 12'd2) && n < 400) begin
            run(1'b1);
            n++;
            n_total++;
            if (obs !== exp_vec()) $display("FAIL gap_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (!(de && x == 12'd3 && y == 12'd2)) $display("FAIL gap_find_pixel got=(%0d,%0d) exp=(3,2)", x, y);
        else n_pass++;
        fc0 = frame_cnt;
        for (int k = 0; k < 5; k++) begin
            run(1'b0);
            n_total++;
            if (obs !== exp_vec()) $display("FAIL gap_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            else n_pass++;
            n_total++;
            if ({de, line_start, frame_start, hs, vs, x, y, frame_cnt} !== {5'b00011, 24'd0, fc0})
                $display("FAIL gap_idle cyc=%0d got=%h exp=%h", cyc,
                         {de, line_start, frame_start, hs, vs, x, y, frame_cnt}, {5'b00011, 24'd0, fc0});
            else n_pass++;
        end
        run(1'b1);
        n_total++;
        if ({frame_start, de, x, y, frame_cnt} !== {2'b11, 24'd0, fc0 + 16'd1})
            $display("FAIL gap_restart got=%h exp=%h", {frame_start, de, x, y, frame_cnt}, {2'b11, 24'd0, fc0 + 16'd1});
        else n_pass++;
    endtask

    task automatic test_random();
        logic e;
        logic [4*CW-1:0] ch, cv;
        int act;
        for (int k = 0; k < 2500; k++) begin
            e = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 11) == 0) begin
                act = ($urandom_range(0, 15) == 0) ? 4090 : int'($urandom_range(0, 12));
                ch = mk(act, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
                cv = mk(int'($urandom_range(0, 8)), int'($urandom_range(0, 4)),
                        int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
                tick(e, 1'b1, ch, cv, 2'($urandom_range(0, 3)));
            end else begin
                run(e);
            end
            n_total++;
            if (obs !== exp_vec()) $display("FAIL rand_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_reset_pending();
        int dec;
        for (int k = 0; k < 20; k++) run(1'b1);
        tick(1'b1, 1'b1, mk(8, 2, 2, 2), mk(4, 1, 1, 1), 2'b11);
        run(1'b1);
        run(1'b1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (obs !== exp_vec()) $display("FAIL rstp_async got=%h exp=%h", obs, exp_vec());
        else n_pass++;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        ls_q.delete();
        fs_q.delete();
        run(1'b1);
        n_total++;
        if ({frame_start, frame_cnt} !== {1'b1, 16'd1})
            $display("FAIL rstp_first got=%h exp=%h", {frame_start, frame_cnt}, {1'b1, 16'd1});
        else n_pass++;
        dec = de ? 1 : 0;
        for (int k = 1; k < 3 * 1344 + 5; k++) begin
            run(1'b1);
            if (k < 1344 && de) dec++;
            n_total++;
            if (obs !== exp_vec()) $display("FAIL rstp_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (dec !== 1024) $display("FAIL rstp_de_len got=%0d exp=1024", dec);
        else n_pass++;
        n_total++;
        if (ls_q.size() < 2 || ls_q[1] - ls_q[0] !== 1344)
            $display("FAIL rstp_ht got=%0d exp=1344", ls_q.size() < 2 ? -1 : ls_q[1] - ls_q[0]);
        else n_pass++;
        // Idle cycles would apply a surviving pending config immediately.
        run(1'b0);
        run(1'b0);
        ls_q.delete();
        for (int k = 0; k < 1400; k++) begin
            run(1'b1);
            n_total++;
            if (obs !== exp_vec()) $display("FAIL rstp_model2 cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (ls_q.size() < 2 || ls_q[1] - ls_q[0] !== 1344)
            $display("FAIL rstp_pending_lost got=%0d exp=1344", ls_q.size() < 2 ? -1 : ls_q[1] - ls_q[0]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_small_cfg();
        test_midframe_cfg();
        test_bad_cfg();
        test_en_gap();
        test_random();
        test_reset_pending();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
